// File: rtl/csa16_pkg.sv
// Shared sizing for the 16-bit carry-select add/subtract unit.
// The adder is built from fixed 4-bit ripple blocks.
package csa16_pkg;
  localparam int WIDTH = 16;
  localparam int BLK   = 4;
  localparam int NBLK  = WIDTH / BLK;

  typedef logic [BLK-1:0] blk_t;
endpackage

// File: rtl/csa16_rca4.sv
// 4-bit ripple-carry adder used as the building block of every carry-select stage.
module rca4
  import csa16_pkg::*;
(
  input  blk_t a,
  input  blk_t b,
  input  logic cin,
  output blk_t sum,
  output logic cout
);
  logic [BLK:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < BLK; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[BLK];
endmodule

// File: rtl/csa16.sv
// Registered 16-bit add/subtract: ripple low block, carry-select upper blocks.
// overflow is the raw carry-out of the top bit (borrow-free flag when subtracting).
module csa16
  import csa16_pkg::*;
#(
  parameter int WIDTH = csa16_pkg::WIDTH,
  parameter int BLK   = csa16_pkg::BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mod,
  output logic [WIDTH-1:0] y,
  output logic             overflow
);
  localparam int NB = WIDTH / BLK;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] y_next;
  logic [NB:0]      carry;
  logic [WIDTH-1:0] y_reg;
  logic             overflow_reg;

  // Subtraction is a + ~b + 1: invert b and feed mod in as the first carry.
  assign bx       = b ^ {WIDTH{mod}};
  assign carry[0] = mod;

  rca4 u_blk0 (
    .a    (a[BLK-1:0]),
    .b    (bx[BLK-1:0]),
    .cin  (carry[0]),
    .sum  (y_next[BLK-1:0]),
    .cout (carry[1])
  );

  for (genvar gi = 1; gi < NB; gi++) begin : g_sel
    blk_t sum0, sum1;
    logic cout0, cout1;

    rca4 u_c0 (
      .a    (a[gi*BLK +: BLK]),
      .b    (bx[gi*BLK +: BLK]),
      .cin  (1'b0),
      .sum  (sum0),
      .cout (cout0)
    );

    rca4 u_c1 (
      .a    (a[gi*BLK +: BLK]),
      .b    (bx[gi*BLK +: BLK]),
      .cin  (1'b1),
      .sum  (sum1),
      .cout (cout1)
    );

    // Both speculative results are ready; the incoming carry only steers the mux.
    assign y_next[gi*BLK +: BLK] = carry[gi] ? sum1  : sum0;
    assign carry[gi+1]           = carry[gi] ? cout1 : cout0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      y_reg        <= y_next;
      overflow_reg <= carry[NB];
    end
  end

  assign y        = y_reg;
  assign overflow = overflow_reg;
endmodule

// File: tb/tb_csa16.sv
// Self-checking bench for csa16: directed vectors, reset cases and a random sweep
// compared against an arithmetic reference model at one-cycle latency.
module tb_csa16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        mod;
  logic [15:0] y;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  csa16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .mod      (mod),
    .y        (y),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic; subtraction carry means "no borrow".
  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mm, input logic mr);
    logic [16:0] r;
    if (!mr)      r = 17'd0;
    else if (!mm) r = {1'b0, ma} + {1'b0, mb};
    else          r = {(ma >= mb), ma - mb};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] ey, input logic eov);
    checks++;
    assert (y === ey) else begin
      errors++;
      $error("FAIL %s y: got %h expected %h", tag, y, ey);
    end
    checks++;
    assert (overflow === eov) else begin
      errors++;
      $error("FAIL %s overflow: got %b expected %b", tag, overflow, eov);
    end
  endtask

  // Apply one vector, clock it, scramble the inputs so a combinational path
  // would be caught, then compare against the model.
  task automatic step(input string tag, input logic [15:0] sa, input logic [15:0] sb,
                      input logic sm, input logic sr, input bit verbose);
    logic [16:0] e;
    a = sa; b = sb; mod = sm; rst_n = sr;
    e = model(sa, sb, sm, sr);
    @(posedge clk);
    #1;
    a = 16'($urandom); b = 16'($urandom); mod = 1'($urandom);
    #1;
    if (verbose)
      $display("%-10s rst_n=%b mod=%b a=%h b=%h -> y=%h ov=%b (exp y=%h ov=%b)",
               tag, sr, sm, sa, sb, y, overflow, e[15:0], e[16]);
    chk(tag, e[15:0], e[16]);
  endtask

  initial begin
    a = 16'hFFFF; b = 16'hFFFF; mod = 1'b0; rst_n = 1'b0;
    #2;

    step("reset0",  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    step("reset1",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    step("blk0c",   16'h000C, 16'h000A, 1'b0, 1'b1, 1'b1);
    step("blk1c",   16'h00C4, 16'h00E2, 1'b0, 1'b1, 1'b1);
    step("blk2c",   16'h0C44, 16'h0C52, 1'b0, 1'b1, 1'b1);
    step("topc",    16'hC444, 16'hCB52, 1'b0, 1'b1, 1'b1);
    step("mixa",    16'h4C44, 16'h8B56, 1'b0, 1'b1, 1'b1);
    step("mixb",    16'h8C44, 16'h0B56, 1'b0, 1'b1, 1'b1);
    step("subge",   16'hCC44, 16'hCB56, 1'b1, 1'b1, 1'b1);
    step("sublt",   16'hFFFE, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    step("subeq",   16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1);
    step("sub0",    16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1);
    step("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    step("allones", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    step("midrst",  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    step("postrst", 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? ra : 16'($urandom);
      step("random", ra, rb, 1'($urandom), ($urandom_range(0, 499) != 0), 1'b0);
    end
    $display("random sweep done: %0d vectors", 10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa16.md
CSA16 -- requirements
Module: csa16

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; fixed at 16, other values unsupported.
REQ-002 Parameter BLK, default 4: carry-select block width; WIDTH SHALL be a multiple of BLK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 a  input  16  operand A, two's complement or unsigned.
REQ-006 b  input  16  operand B, two's complement or unsigned.
REQ-007 mod  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 y  output  16  registered result.
REQ-009 overflow  output  1  registered carry-out of bit 15.

Function
REQ-010 mod=0: y SHALL equal (a + b) mod 2^16.
REQ-011 mod=1: y SHALL equal (a + ~b + 1) mod 2^16, i.e. a - b in two's complement.
REQ-012 Operand B SHALL be conditioned as b XOR {16{mod}}, with mod as carry-in of the lowest block.
REQ-013 overflow SHALL be the raw carry-out c16 of the 17-bit sum a + (b^mod) + mod in both modes, not signed overflow.
REQ-014 Adder: lowest BLK-bit block is ripple-carry with cin=mod.
REQ-015 Each higher block SHALL compute two sums in parallel, one for cin=0 and one for cin=1.
REQ-016 Each higher block's sum and carry-out SHALL be selected by the previous block's carry-out.
REQ-017 Datapath a,b,mod -> y,overflow SHALL be combinational, then registered: latency exactly 1 clk.
REQ-018 y and overflow SHALL update every cycle with no enable and no handshake; new inputs are accepted every cycle.
REQ-019 Wrap-around: results beyond 16 bits SHALL be truncated, with the carry visible only on overflow.
REQ-020 With mod=1 and a<b (unsigned), overflow SHALL be 0.
REQ-021 With mod=1 and a>=b (unsigned), overflow SHALL be 1.
REQ-022 There SHALL be no X-propagation: every output bit is driven from defined logic once reset has been applied.

Reset
REQ-023 When rst_n=0 at a rising clk edge, y SHALL be 16'h0000 and overflow SHALL be 0 on the next cycle.
REQ-024 Reset SHALL take precedence over any input, including reset asserted mid-stream.
REQ-025 The first result after rst_n deasserts SHALL appear one cycle after the first sampled inputs.

Structure
REQ-026 A shared package SHALL hold WIDTH=16, BLK=4, and NBLK=WIDTH/BLK.
REQ-027 One sub-module rca4 (4-bit ripple-carry adder: a, b, cin -> sum, cout) SHALL be instantiated.
REQ-028 rca4 SHALL be instantiated once for block 0 and twice (cin=0, cin=1) for each of blocks 1..3.
REQ-029 The carry-select muxes and the output register SHALL live in csa16.

Verification
REQ-030 mod=0, a=16'h000C, b=16'h000A -> next cycle y=16'h0016, overflow=0 (block-0 carry into bit 4).
REQ-031 mod=0, a=16'h00C4, b=16'h00E2 -> y=16'h01A6, overflow=0; a=16'h0C44, b=16'h0C52 -> y=16'h1896, overflow=0.
REQ-032 mod=0, a=16'hC444, b=16'hCB52 -> y=16'h8F96, overflow=1 (carry out of top block).
REQ-033 mod=0, a=16'h4C44, b=16'h8B56 -> y=16'hD79A, overflow=0; a=16'h8C44, b=16'h0B56 -> y=16'h979A, overflow=0.
REQ-034 mod=1, a=16'hCC44, b=16'hCB56 -> y=16'h00EE, overflow=1; a=16'hFFFE, b=16'hFFFF -> y=16'hFFFF, overflow=0.
REQ-035 Apply rst_n=0 with a=b=16'hFFFF -> y=0, overflow=0 next cycle; after release, a 10k-vector random compare against a+(mod?-b:b) at 1-cycle latency SHALL pass.
